// File: rtl/vec_operand_loader_pkg.sv
// Shared definitions for the vector operand loader.
// Holds the load-sequencer state encoding, the lane geometry and the
// default byte stride between consecutive lane addresses.
package vec_operand_loader_pkg;

  // Sequencer states: idle, streaming vector A, streaming vector B, holding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_LANES      = 5;
  localparam int LANE_IDX_W     = 3;
  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STRIDE = 4;

endpackage

// File: rtl/vec_operand_loader_if.sv
// Bundle between the operand loader, the data-memory read port, the
// requester that issues loads and the vector ALU that consumes the lanes.
//   start, a_base, b_base : load request and the two lane-0 byte addresses
//   mem_addr, mem_re      : read request to data memory
//   mem_rdata             : combinational read data for mem_addr
//   a[], b[]              : registered operand lanes for the vector ALU
//   busy, valid, done     : load in progress / lanes coherent / first valid cycle
// The slave modport is the loader itself; master is its environment.
interface vec_operand_loader_if
  import vec_operand_loader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a_base;
  logic [WIDTH-1:0] b_base;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_re;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] a [NUM_LANES];
  logic [WIDTH-1:0] b [NUM_LANES];
  logic             busy;
  logic             valid;
  logic             done;

  modport slave (
    input  start, a_base, b_base, mem_rdata,
    output mem_addr, mem_re, a, b, busy, valid, done
  );

  modport master (
    output start, a_base, b_base, mem_rdata,
    input  mem_addr, mem_re, a, b, busy, valid, done
  );

endinterface

// File: rtl/vec_operand_loader_addr_gen.sv
// Address generator for the operand loader.
// Latches both base addresses when a load is accepted, counts the lane
// index 0..NUM_LANES-1 once per load cycle, and forms base + index*STRIDE
// for whichever vector is currently streaming.
//   load_i   : a new load was accepted; latch bases and clear the index
//   step_i   : a lane was read this cycle; advance the index
//   sel_b_i  : address vector B instead of vector A
//   a_base_i, b_base_i : lane-0 byte addresses from the requester
//   addr_o   : byte address of the current lane (wraps modulo 2^WIDTH)
//   idx_o    : current lane index
//   last_o   : current lane is the final lane of a vector
module vec_addr_gen
  import vec_operand_loader_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STRIDE = DEFAULT_STRIDE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  sel_b_i,
  input  logic [WIDTH-1:0]      a_base_i,
  input  logic [WIDTH-1:0]      b_base_i,
  output logic [WIDTH-1:0]      addr_o,
  output logic [LANE_IDX_W-1:0] idx_o,
  output logic                  last_o
);

  logic [WIDTH-1:0]      a_base_q;
  logic [WIDTH-1:0]      b_base_q;
  logic [LANE_IDX_W-1:0] idx_q;
  logic [LANE_IDX_W-1:0] idx_d;

  // The index wraps back to zero after the last lane so that the switch
  // from vector A to vector B starts at lane 0 without extra control.
  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = '0;
    end else if (step_i) begin
      idx_d = last_o ? '0 : idx_q + 1'b1;
    end
  end

  // Bases are captured only on an accepted load, so a start that arrives
  // mid-load cannot disturb the addresses of the load in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_base_q <= '0;
      b_base_q <= '0;
      idx_q    <= '0;
    end else begin
      if (load_i) begin
        a_base_q <= a_base_i;
        b_base_q <= b_base_i;
      end
      idx_q <= idx_d;
    end
  end

  // Plain WIDTH-bit addition; overflow past the top of memory simply wraps.
  assign addr_o = (sel_b_i ? b_base_q : a_base_q) + WIDTH'(idx_q) * WIDTH'(STRIDE);
  assign idx_o  = idx_q;
  assign last_o = (idx_q == LANE_IDX_W'(NUM_LANES - 1));

endmodule

// File: rtl/vec_operand_loader.sv
// Vector operand loader: on a start request streams five words for vector A
// then five for vector B from data memory, one per cycle, into registered
// lanes, then holds them with valid high until the next start.
//   clk   : system clock
//   reset : asynchronous active-high reset, clears all state and lanes
//   lb    : loader bus (request, memory port, lanes, status)
module vec_operand_loader
  import vec_operand_loader_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STRIDE = DEFAULT_STRIDE
) (
  input  logic                  clk,
  input  logic                  reset,
  vec_operand_loader_if.slave   lb
);

  state_e                state_q;
  state_e                state_d;
  logic                  done_q;
  logic                  accept;
  logic                  loading;
  logic                  last;
  logic [WIDTH-1:0]      addr;
  logic [LANE_IDX_W-1:0] idx;
  logic [WIDTH-1:0]      a_q [NUM_LANES];
  logic [WIDTH-1:0]      b_q [NUM_LANES];

  vec_addr_gen #(
    .WIDTH  (WIDTH),
    .STRIDE (STRIDE)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept),
    .step_i   (loading),
    .sel_b_i  (state_q == LOAD_B),
    .a_base_i (lb.a_base),
    .b_base_i (lb.b_base),
    .addr_o   (addr),
    .idx_o    (idx),
    .last_o   (last)
  );

  // Next-state logic. A start is only honoured when no load is running,
  // which is what makes mid-load start pulses harmless.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    loading = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lb.start) begin
          accept  = 1'b1;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        loading = 1'b1;
        if (last) state_d = LOAD_B;
      end
      LOAD_B: begin
        loading = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (lb.start) begin
          accept  = 1'b1;
          state_d = LOAD_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the done pulse, which fires on the edge that moves
  // the sequencer into DONE and therefore lasts exactly one DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE) && (state_q != DONE);
    end
  end

  // Each lane is written only in its own load cycle; every other cycle it
  // holds, so A lanes already carry new data while B is still streaming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        a_q[l] <= '0;
        b_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (state_q == LOAD_A && idx == LANE_IDX_W'(l)) a_q[l] <= lb.mem_rdata;
        if (state_q == LOAD_B && idx == LANE_IDX_W'(l)) b_q[l] <= lb.mem_rdata;
      end
    end
  end

  // Outputs to the bus. The address is forced to zero outside load cycles
  // so memory never sees a stale address with read enable low.
  always_comb begin
    lb.mem_re   = loading;
    lb.busy     = loading;
    lb.valid    = (state_q == DONE);
    lb.done     = done_q;
    lb.mem_addr = loading ? addr : '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lb.a[l] = a_q[l];
      lb.b[l] = b_q[l];
    end
  end

endmodule
